// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer and its synchroniser.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_WIDTH     = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Latency: 2 cycles from d to q.
// Backpressure: none, free-running.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a noisy async input into a clean level with one-cycle rise/fall pulses.
// Latency: STABLE_CYCLES+3 edges from first stable raw sample to clean/pulse.
// Backpressure: none; glitches of STABLE_CYCLES sampled edges or fewer are dropped.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] STABLE_MAX = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic                 s2;
    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 clean_nxt, rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw),
        .q     (s2)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clean_nxt = clean;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt < STABLE_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else begin
                    state_nxt = IDLE_HIGH;
                    clean_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt < STABLE_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else begin
                    state_nxt = IDLE_LOW;
                    clean_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset drops clean directly, so no fall pulse is produced by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            clean <= clean_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed test-plan scenarios plus random raw runs, two parameterisations.
module tb_input_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic raw;
    logic clean0, rise0, fall0, busy0;
    logic clean1, rise1, fall1, busy1;

    always #5 clk = ~clk;

    input_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .raw(raw),
        .clean(clean0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    input_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(3)) dut1 (
        .clk(clk), .reset(reset), .raw(raw),
        .clean(clean1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Reference: a level is accepted once the twice-delayed input has disagreed
    // with the current clean level for N+1 consecutive edges.
    int   m_n   [2] = '{4, 1};
    int   m_run [2];
    logic m_h1  [2];
    logic m_h2  [2];
    logic m_clean [2];
    logic m_rise  [2];
    logic m_fall  [2];

    task automatic model_edge(input logic r, input logic rs);
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                m_h1[i] = 1'b0; m_h2[i] = 1'b0; m_run[i] = 0;
                m_clean[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
            end else begin
                logic in_v;
                in_v = m_h2[i];
                m_h2[i] = m_h1[i];
                m_h1[i] = r;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (in_v != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == m_n[i] + 1) begin
                        m_clean[i] = in_v;
                        m_rise[i]  = in_v;
                        m_fall[i]  = !in_v;
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic rs);
        raw   = r;
        reset = rs;
        @(posedge clk);
        model_edge(r, rs);
        @(negedge clk);
        chk("clean0", clean0, m_clean[0]);
        chk("rise0",  rise0,  m_rise[0]);
        chk("fall0",  fall0,  m_fall[0]);
        chk("busy0",  busy0,  m_run[0] != 0);
        chk("excl0",  rise0 & fall0, 1'b0);
        chk("clean1", clean1, m_clean[1]);
        chk("rise1",  rise1,  m_rise[1]);
        chk("fall1",  fall1,  m_fall[1]);
        chk("busy1",  busy1,  m_run[1] != 0);
        chk("excl1",  rise1 & fall1, 1'b0);
    endtask

    initial begin
        logic [5:0] bounce;
        int rises;
        raw   = 1'b0;
        reset = 1'b1;

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset_clean", clean0, 1'b0);
        chk("reset_busy",  busy0,  1'b0);

        // clean press
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            if (e >= 3 && e <= 6) chk("press_busy", busy0, 1'b1);
            if (e == 6) chk("press_clean_e6", clean0, 1'b0);
            if (e == 7) begin
                chk("press_rise_e7",  rise0,  1'b1);
                chk("press_clean_e7", clean0, 1'b1);
            end
            if (e == 8) chk("press_rise_e8", rise0, 1'b0);
        end

        // release
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b0);
            chk("release_norise", rise0, 1'b0);
            if (e == 7) begin
                chk("release_fall_e7",  fall0,  1'b1);
                chk("release_clean_e7", clean0, 1'b0);
            end
            if (e == 8) chk("release_fall_e8", fall0, 1'b0);
        end

        // short glitch: 4 edges high
        for (int e = 1; e <= 12; e++) begin
            step(e <= 4, 1'b0);
            chk("glitch_clean", clean0, 1'b0);
            chk("glitch_rise",  rise0,  1'b0);
            if (e >= 8) chk("glitch_busy", busy0, 1'b0);
        end

        // bounce 1,0,1,1,0,1 then hold 1
        bounce = 6'b101101;
        rises  = 0;
        for (int e = 1; e <= 16; e++) begin
            step((e <= 6) ? bounce[6 - e] : 1'b1, 1'b0);
            if (rise0) rises++;
            if (e == 12) chk("bounce_rise_e12", rise0, 1'b1);
        end
        chk("bounce_one_rise", rises == 1, 1'b1);
        for (int e = 1; e <= 10; e++) step(1'b0, 1'b0);

        // reset while WAIT_HIGH with cnt=3, then re-qualify from scratch
        for (int e = 1; e <= 5; e++) step(1'b1, 1'b0);
        chk("mid_busy_pre", busy0, 1'b1);
        step(1'b1, 1'b1);
        chk("mid_clean", clean0, 1'b0);
        chk("mid_rise",  rise0,  1'b0);
        chk("mid_fall",  fall0,  1'b0);
        chk("mid_busy",  busy0,  1'b0);
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            if (e == 6) chk("requal_clean_e6", clean0, 1'b0);
            if (e == 7) chk("requal_rise_e7",  rise0,  1'b1);
        end

        // reset while clean=1
        chk("pre_reset_clean", clean0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_hi_clean", clean0, 1'b0);
        chk("rst_hi_fall",  fall0,  1'b0);
        for (int e = 1; e <= 4; e++) step(1'b0, 1'b0);

        // STABLE_CYCLES=1: two edges accepted at edge 4, one edge rejected
        for (int e = 1; e <= 10; e++) begin
            step(e <= 2, 1'b0);
            if (e == 3) chk("n1_clean_e3", clean1, 1'b0);
            if (e == 4) begin
                chk("n1_rise_e4",  rise1,  1'b1);
                chk("n1_clean_e4", clean1, 1'b1);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            step(e == 1, 1'b0);
            chk("n1_short_clean", clean1, 1'b0);
            chk("n1_short_rise",  rise1,  1'b0);
        end

        // random runs with occasional reset
        for (int k = 0; k < 600; k++) begin
            logic lvl;
            int   hold;
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++)
                step(lvl, $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
